// File: rtl/program_loader_pkg.sv
// Shared constants and state type for the instruction loader.
package program_loader_pkg;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        RUN,
        ERR
    } state_e;
endpackage

// File: rtl/program_loader_if.sv
// Valid/ready instruction stream carrying a length header followed by instruction words.
interface program_loader_if #(
    parameter int unsigned DATA_W = program_loader_pkg::DATA_W
) ();
    import program_loader_pkg::*;

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/program_loader_wr_ptr.sv
// Write pointer and remaining-word counter for one program load.
module loader_wr_ptr #(
    parameter int unsigned ADDR_W = program_loader_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              last_o
);
    import program_loader_pkg::*;

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;

    always_comb begin
        ptr_d = ptr_q;
        rem_d = rem_q;
        if (load_i) begin
            ptr_d = '0;
            rem_d = len_i;
        end else if (step_i) begin
            ptr_d = ptr_q + ADDR_W'(1);
            rem_d = rem_q - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            rem_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            rem_q <= rem_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign last_o = (rem_q == (ADDR_W+1)'(1));
endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed program into instruction memory, then runs the core until halt.
module program_loader #(
    parameter int unsigned DATA_W = program_loader_pkg::DATA_W,
    parameter int unsigned ADDR_W = program_loader_pkg::ADDR_W,
    parameter int unsigned DEPTH  = program_loader_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    program_loader_if.slave   s_if,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              core_rstn_o,
    output logic              core_ce_o,
    input  logic              halt_i,
    output logic              load_done_o,
    output logic              load_err_o
);
    import program_loader_pkg::*;

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);

    state_e            state_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              core_rstn_q;
    logic              core_ce_q;
    logic              load_done_q;
    logic              load_err_q;

    logic              hs;
    logic [ADDR_W:0]   len_d;
    logic              len_ok_d;
    logic              ptr_load;
    logic              ptr_step;
    logic [ADDR_W-1:0] ptr;
    logic              last;

    assign s_if.s_ready = (state_q == HDR) || (state_q == LOAD);
    assign hs           = s_if.s_valid & s_if.s_ready;

    // Only the low ADDR_W+1 header bits carry the length, so DEPTH itself is representable.
    assign len_d    = s_if.s_data[ADDR_W:0];
    assign len_ok_d = (len_d != '0) && (len_d <= MAX_LEN);
    assign ptr_load = (state_q == HDR) && hs && len_ok_d;
    assign ptr_step = (state_q == LOAD) && hs;

    loader_wr_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .load_i(ptr_load),
        .len_i (len_d),
        .step_i(ptr_step),
        .ptr_o (ptr),
        .last_o(last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_rstn_q <= 1'b0;
            core_ce_q   <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                IDLE, ERR: begin
                    if (start_i) begin
                        state_q     <= HDR;
                        core_rstn_q <= 1'b0;
                        core_ce_q   <= 1'b0;
                        load_done_q <= 1'b0;
                        load_err_q  <= 1'b0;
                    end
                end
                HDR: begin
                    if (hs) begin
                        if (len_ok_d) begin
                            state_q <= LOAD;
                        end else begin
                            state_q    <= ERR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (hs) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ptr;
                        mem_wdata_q <= s_if.s_data;
                        if (last) begin
                            state_q     <= RUN;
                            load_done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Release lags RUN entry by a cycle so the final write lands before the first fetch.
                    if (halt_i) begin
                        state_q   <= IDLE;
                        core_ce_q <= 1'b0;
                    end else begin
                        core_rstn_q <= 1'b1;
                        core_ce_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign core_rstn_o = core_rstn_q;
    assign core_ce_o   = core_ce_q;
    assign load_done_o = load_done_q;
    assign load_err_o  = load_err_q;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized loads against a write-list model.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        rst, start, halt;
    logic        mem_we, core_rstn, core_ce, load_done, load_err;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t wr_log[$];

    always #5 clk = ~clk;

    program_loader_if sif ();

    program_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .s_if       (sif),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .core_rstn_o(core_rstn),
        .core_ce_o  (core_ce),
        .halt_i     (halt),
        .load_done_o(load_done),
        .load_err_o (load_err)
    );

    always @(negedge clk) if (mem_we === 1'b1) wr_log.push_back('{a: mem_addr, d: mem_wdata});

    // Reference rule: valid lengths are 1..32 taken from header modulo 64; 0 means the load is rejected.
    function automatic int ref_len(input logic [15:0] hdr);
        int l;
        l = int'(hdr) % 64;
        return (l >= 1 && l <= 32) ? l : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic to_idle();
        sif.s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] w);
        bit hs;
        hs = 1'b0;
        sif.s_valid = 1'b1;
        sif.s_data  = w;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = sif.s_ready;
            tick();
        end
        sif.s_valid = 1'b0;
        if (!hs) begin
            checks++;
            $display("FAIL push_timeout: s_ready=%b required 1 within 20 cycles", sif.s_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; halt = 1'b0; sif.s_valid = 1'b0; sif.s_data = '0;
        tick(); tick();
        checks++; if (sif.s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", sif.s_ready); else passes++;
        checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else passes++;
        checks++; if (mem_addr !== 5'd0) $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); else passes++;
        checks++; if (mem_wdata !== 16'h0) $display("FAIL rst_mem_wdata: got %h want 0000", mem_wdata); else passes++;
        checks++; if (core_rstn !== 1'b0) $display("FAIL rst_core_rstn: got %b want 0", core_rstn); else passes++;
        checks++; if (core_ce !== 1'b0) $display("FAIL rst_core_ce: got %b want 0", core_ce); else passes++;
        checks++; if (load_done !== 1'b0) $display("FAIL rst_load_done: got %b want 0", load_done); else passes++;
        checks++; if (load_err !== 1'b0) $display("FAIL rst_load_err: got %b want 0", load_err); else passes++;
        rst = 1'b0;
        tick();
        checks++; if (sif.s_ready !== 1'b0) $display("FAIL idle_s_ready: got %b want 0", sif.s_ready); else passes++;
    endtask

    task automatic test_nominal();
        logic [15:0] w [3];
        w[0] = 16'hA001; w[1] = 16'hA002; w[2] = 16'hA003;
        to_idle();
        wr_log.delete();
        pulse_start();
        checks++; if (sif.s_ready !== 1'b1) $display("FAIL nom_hdr_ready: got %b want 1", sif.s_ready); else passes++;
        push_word(16'd3);
        push_word(w[0]);
        checks++; if (load_done !== 1'b0) $display("FAIL nom_early_done: got %b want 0", load_done); else passes++;
        push_word(w[1]);
        push_word(w[2]);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 5'd2 || mem_wdata !== 16'hA003)
            $display("FAIL nom_last_write: got we=%b addr=%0d data=%h want we=1 addr=2 data=a003", mem_we, mem_addr, mem_wdata); else passes++;
        checks++; if (load_done !== 1'b1) $display("FAIL nom_done: got %b want 1", load_done); else passes++;
        checks++; if (core_rstn !== 1'b0 || core_ce !== 1'b0)
            $display("FAIL nom_core_held: got rstn=%b ce=%b want 0 0", core_rstn, core_ce); else passes++;
        checks++; if (sif.s_ready !== 1'b0) $display("FAIL nom_run_ready: got %b want 0", sif.s_ready); else passes++;
        tick();
        checks++; if (core_rstn !== 1'b1 || core_ce !== 1'b1 || mem_we !== 1'b0)
            $display("FAIL nom_release: got rstn=%b ce=%b we=%b want 1 1 0", core_rstn, core_ce, mem_we); else passes++;
        checks++; if (wr_log.size() !== 3) $display("FAIL nom_write_count: got %0d want 3", wr_log.size()); else passes++;
        for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
            checks++;
            if (wr_log[i].a !== 5'(i) || wr_log[i].d !== w[i])
                $display("FAIL nom_write%0d: got addr=%0d data=%h want addr=%0d data=%h", i, wr_log[i].a, wr_log[i].d, i, w[i]);
            else passes++;
        end
    endtask

    task automatic test_halt_restart();
        halt = 1'b1; start = 1'b1;
        tick();
        halt = 1'b0; start = 1'b0;
        checks++; if (core_ce !== 1'b0 || core_rstn !== 1'b1 || load_done !== 1'b1)
            $display("FAIL halt_outputs: got ce=%b rstn=%b done=%b want 0 1 1", core_ce, core_rstn, load_done); else passes++;
        checks++; if (sif.s_ready !== 1'b0) $display("FAIL halt_start_ignored: got s_ready=%b want 0", sif.s_ready); else passes++;
        tick();
        checks++; if (sif.s_ready !== 1'b0 || core_rstn !== 1'b1)
            $display("FAIL halt_idle_hold: got s_ready=%b rstn=%b want 0 1", sif.s_ready, core_rstn); else passes++;
        pulse_start();
        checks++; if (core_rstn !== 1'b0 || core_ce !== 1'b0 || load_done !== 1'b0 || sif.s_ready !== 1'b1)
            $display("FAIL restart: got rstn=%b ce=%b done=%b ready=%b want 0 0 0 1", core_rstn, core_ce, load_done, sif.s_ready); else passes++;
    endtask

    task automatic test_bubbles();
        to_idle();
        wr_log.delete();
        pulse_start();
        push_word(16'd2);
        push_word(16'hB001);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 5'd0)
            $display("FAIL bub_first: got we=%b addr=%0d want 1 0", mem_we, mem_addr); else passes++;
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            tick();
            start = 1'b0;
            checks++;
            if (mem_we !== 1'b0 || load_done !== 1'b0 || sif.s_ready !== 1'b1)
                $display("FAIL bub_gap%0d: got we=%b done=%b ready=%b want 0 0 1", i, mem_we, load_done, sif.s_ready);
            else passes++;
        end
        push_word(16'hB002);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 5'd1 || mem_wdata !== 16'hB002 || load_done !== 1'b1)
            $display("FAIL bub_second: got we=%b addr=%0d data=%h done=%b want 1 1 b002 1", mem_we, mem_addr, mem_wdata, load_done); else passes++;
        tick();
        checks++; if (wr_log.size() !== 2) $display("FAIL bub_write_count: got %0d want 2", wr_log.size()); else passes++;
    endtask

    task automatic test_bad_len();
        logic [15:0] bad [2];
        bad[0] = 16'd0; bad[1] = 16'd33;
        to_idle();
        wr_log.delete();
        for (int k = 0; k < 2; k++) begin
            pulse_start();
            checks++; if (load_err !== 1'b0 || sif.s_ready !== 1'b1)
                $display("FAIL bad_enter_hdr%0d: got err=%b ready=%b want 0 1", k, load_err, sif.s_ready); else passes++;
            push_word(bad[k]);
            checks++; if (load_err !== 1'b1 || sif.s_ready !== 1'b0 || core_rstn !== 1'b0 || core_ce !== 1'b0)
                $display("FAIL bad_err%0d: got err=%b ready=%b rstn=%b ce=%b want 1 0 0 0", k, load_err, sif.s_ready, core_rstn, core_ce); else passes++;
            sif.s_valid = 1'b1; sif.s_data = 16'h1234;
            tick();
            sif.s_valid = 1'b0;
            checks++; if (load_err !== 1'b1 || mem_we !== 1'b0)
                $display("FAIL bad_hold%0d: got err=%b we=%b want 1 0", k, load_err, mem_we); else passes++;
        end
        pulse_start();
        checks++; if (load_err !== 1'b0 || sif.s_ready !== 1'b1)
            $display("FAIL bad_recover: got err=%b ready=%b want 0 1", load_err, sif.s_ready); else passes++;
        checks++; if (wr_log.size() !== 0) $display("FAIL bad_no_writes: got %0d want 0", wr_log.size()); else passes++;
    endtask

    task automatic test_full_depth();
        logic [15:0] w [32];
        int bad;
        to_idle();
        wr_log.delete();
        pulse_start();
        push_word(16'd32);
        for (int i = 0; i < 32; i++) begin
            w[i] = 16'($urandom);
            push_word(w[i]);
        end
        checks++; if (mem_addr !== 5'd31 || load_done !== 1'b1)
            $display("FAIL full_last: got addr=%0d done=%b want 31 1", mem_addr, load_done); else passes++;
        tick();
        checks++; if (mem_we !== 1'b0 || core_rstn !== 1'b1)
            $display("FAIL full_no_wrap: got we=%b rstn=%b want 0 1", mem_we, core_rstn); else passes++;
        checks++; if (wr_log.size() !== 32) $display("FAIL full_write_count: got %0d want 32", wr_log.size()); else passes++;
        bad = 0;
        for (int i = 0; i < 32 && i < wr_log.size(); i++)
            if (wr_log[i].a !== 5'(i) || wr_log[i].d !== w[i]) begin
                if (bad == 0)
                    $display("FAIL full_write%0d: got addr=%0d data=%h want addr=%0d data=%h", i, wr_log[i].a, wr_log[i].d, i, w[i]);
                bad++;
            end
        checks++; if (bad != 0) $display("FAIL full_contents: got %0d bad entries want 0", bad); else passes++;
    endtask

    task automatic test_reset_mid_load();
        to_idle();
        wr_log.delete();
        pulse_start();
        push_word(16'd10);
        for (int i = 0; i < 5; i++) push_word(16'hC000 + 16'(i));
        sif.s_valid = 1'b1; sif.s_data = 16'hC005;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 5'd0 || mem_wdata !== 16'h0 || sif.s_ready !== 1'b0)
            $display("FAIL mid_rst_mem: got we=%b addr=%0d data=%h ready=%b want 0 0 0000 0", mem_we, mem_addr, mem_wdata, sif.s_ready); else passes++;
        checks++; if (core_rstn !== 1'b0 || core_ce !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0)
            $display("FAIL mid_rst_ctrl: got rstn=%b ce=%b done=%b err=%b want 0 0 0 0", core_rstn, core_ce, load_done, load_err); else passes++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mem_we !== 1'b0 || sif.s_ready !== 1'b0)
                $display("FAIL mid_rst_ignore%0d: got we=%b ready=%b want 0 0", i, mem_we, sif.s_ready);
            else passes++;
        end
        sif.s_valid = 1'b0;
        checks++; if (wr_log.size() !== 5) $display("FAIL mid_rst_count: got %0d want 5", wr_log.size()); else passes++;
    endtask

    task automatic test_random();
        logic [15:0] hdr, upper;
        logic [15:0] w [32];
        int n, l, bad;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(0, 9);
            l = (n == 0) ? 0 : (n == 1) ? $urandom_range(33, 63) : $urandom_range(1, 32);
            upper = 16'($urandom);
            hdr = {upper[15:6], 6'(l)};
            to_idle();
            wr_log.delete();
            pulse_start();
            push_word(hdr);
            if (ref_len(hdr) == 0) begin
                checks++; if (load_err !== 1'b1 || sif.s_ready !== 1'b0)
                    $display("FAIL rnd%0d_err: hdr=%h got err=%b ready=%b want 1 0", it, hdr, load_err, sif.s_ready); else passes++;
            end else begin
                for (int i = 0; i < ref_len(hdr); i++) begin
                    w[i] = 16'($urandom);
                    repeat ($urandom_range(0, 2)) tick();
                    push_word(w[i]);
                end
                checks++; if (load_done !== 1'b1 || load_err !== 1'b0)
                    $display("FAIL rnd%0d_done: hdr=%h got done=%b err=%b want 1 0", it, hdr, load_done, load_err); else passes++;
                tick();
                checks++; if (core_ce !== 1'b1 || core_rstn !== 1'b1)
                    $display("FAIL rnd%0d_run: got ce=%b rstn=%b want 1 1", it, core_ce, core_rstn); else passes++;
            end
            checks++; if (wr_log.size() !== ref_len(hdr))
                $display("FAIL rnd%0d_count: hdr=%h got %0d want %0d", it, hdr, wr_log.size(), ref_len(hdr)); else passes++;
            bad = 0;
            for (int i = 0; i < ref_len(hdr) && i < wr_log.size(); i++)
                if (wr_log[i].a !== 5'(i) || wr_log[i].d !== w[i]) bad++;
            checks++; if (bad != 0) $display("FAIL rnd%0d_contents: got %0d bad entries want 0", it, bad); else passes++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_halt_restart();
        test_bubbles();
        test_bad_len();
        test_full_depth();
        test_reset_mid_load();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
